muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, beside the single-cycle ALU.
- It consumes a 3-bit M-extension operation code, which is funct3 of an OP/funct7=0000001 instruction as produced by the control unit.
- Computation is multi-cycle, with a start/busy/done handshake that the hazard unit uses to stall the pipeline.
- It supports a flush input so a squashed instruction can be aborted.

Parameters:
- WIDTH, 32, operand/result width in bits. The iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation. Sampled only in IDLE or DONE.
- flush  input  1  synchronous abort of any in-flight operation.
- mdcontrol  input  3  op: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- srca  input  WIDTH  rs1 operand, captured when start is accepted.
- srcb  input  WIDTH  rs2 operand, captured when start is accepted.
- busy  output  1  high in CALC and FIX.
- done  output  1  one-cycle pulse; mdresult is valid.
- mdresult  output  WIDTH  result register. Held until the next completion.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, internal registers=0.
  - busy=0, done=0, mdresult=0 immediately.
  - Applies even mid-operation.
- States: IDLE, CALC, FIX, DONE. busy = (CALC|FIX). done = (state==DONE).
- Start acceptance:
  - Accepted when start=1, flush=0 and state is IDLE or DONE. Back-to-back starts from DONE are allowed.
  - start in CALC/FIX is ignored; no queuing.
- On accept: latch op, srca, srcb.
  - Signedness per op: mul/mulh/div/rem signed/signed; mulhsu signed/unsigned; mulhu/divu/remu unsigned.
  - Convert operands to magnitudes and record result sign.
- Fast path: evaluated at accept, next state DONE, so done is high in the cycle after start.
  - div/divu by zero: quotient all-ones.
  - rem/remu by zero: result = srca.
  - div overflow (srca=0x80000000, srcb=0xFFFFFFFF): quotient 0x80000000; rem result 0.
- Normal path: IDLE -> CALC.
  - counter loaded with WIDTH-1 and decremented each CALC cycle.
  - Leave CALC after WIDTH cycles (counter==0) -> FIX.
- Multiply: unsigned shift-add into a 2*WIDTH product, one multiplier bit per cycle.
- Divide: restoring division, one quotient bit per cycle, with WIDTH+1-bit remainder.
- FIX (1 cycle):
  - Negate product if result sign is negative.
  - Quotient sign = sa^sb. Remainder sign = sign of dividend.
  - Select low product for mul, high for mulh/mulhsu/mulhu, quotient for div/divu, remainder for rem/remu.
  - Write mdresult; next state DONE.
- Latency: start accepted in cycle 0 -> CALC cycles 1..WIDTH -> FIX cycle WIDTH+1 -> done high in cycle WIDTH+2 (34 at default).
- DONE -> IDLE next edge unless a new start is accepted (then CALC, or DONE again for fast path).
- flush=1: next state IDLE from any state; no done; mdresult unchanged. flush with start in the same cycle: flush wins, start dropped.
- Operand changes after accept have no effect.

Decomposition:
- Shared package muldiv_pkg holds the mdcontrol encodings (MD_MUL..MD_REMU), the state enum typedef, and the default XLEN=32.
- Single module; no sub-module is natural. Datapath and FSM stay together, so sign handling and fast-path detection share the latched op.

Test Plan:
- mul, srca=7, srcb=0xFFFFFFFD (-3), start cycle 0 -> busy cycles 1..33, done exactly in cycle 34, mdresult=0xFFFFFFEB.
- mulh 0x80000000*0x80000000 -> 0x40000000.
- mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- mulhsu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 100/7 -> 14; remu 100/7 -> 2; each done in cycle 34.
- div 5/0 -> 0xFFFFFFFF with done in cycle 1; rem 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000; rem of same -> 0. busy never asserts.
- Abort and back-to-back: flush in cycle 10 -> state IDLE, busy=0 in cycle 11, no done pulse, mdresult keeps prior value. start pulses in cycles 5..20 during a run are ignored. start during DONE -> new op accepted, second done 34 cycles later.
- rst_n low in cycle 15 mid-CALC -> busy/done/mdresult 0 without a clock edge. After release, a divu 9/3 completes with 3 in cycle 34.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    // M-extension funct3 encodings as delivered by the control unit
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes,
// sign correction in a single FIX cycle, divide corner cases short-circuited.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       mdcontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mdresult
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state, nxt;
    logic [CW-1:0]      cnt;
    logic [2:0]         op;
    logic               sa, sb;
    logic [WIDTH-1:0]   mcand;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] prod;    // {partial sum, remaining multiplier bits}
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;     // dividend bits shift out as quotient bits shift in

    logic               accept;
    logic               a_sgn_op, b_sgn_op, in_sa, in_sb;
    logic [WIDTH-1:0]   amag, bmag;
    logic               is_div, is_rem, div_zero, div_ovf, fast;
    logic [WIDTH-1:0]   fast_res;
    logic [WIDTH:0]     msum, rtrial, rdiff;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, res_fix;

    // Operand decode at the accept point: signedness, magnitudes, corner cases
    always_comb begin
        accept   = start && !flush && (state == ST_IDLE || state == ST_DONE);
        a_sgn_op = (mdcontrol != MD_MULHU) && (mdcontrol != MD_DIVU) && (mdcontrol != MD_REMU);
        b_sgn_op = a_sgn_op && (mdcontrol != MD_MULHSU);
        in_sa    = a_sgn_op && srca[WIDTH-1];
        in_sb    = b_sgn_op && srcb[WIDTH-1];
        amag     = in_sa ? -srca : srca;
        bmag     = in_sb ? -srcb : srcb;
        is_div   = mdcontrol[2];
        is_rem   = mdcontrol[1];
        div_zero = is_div && (srcb == '0);
        // only the signed divide/remainder can overflow
        div_ovf  = is_div && !mdcontrol[0] && (srca == {1'b1, {(WIDTH-1){1'b0}}})
                   && (srcb == '1);
        fast     = div_zero || div_ovf;
        fast_res = '0;
        if (div_zero)
            fast_res = is_rem ? srca : '1;
        else if (div_ovf)
            fast_res = is_rem ? '0 : srca;
    end

    // One iteration step of shift-add multiply and restoring divide
    always_comb begin
        msum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        rtrial = {rem, quo[WIDTH-1]};
        rdiff  = rtrial - {1'b0, mcand};
    end

    // Sign correction and result selection for the FIX cycle
    always_comb begin
        prod_s = (sa ^ sb) ? -prod : prod;
        quo_s  = (sa ^ sb) ? -quo : quo;
        rem_s  = sa ? -rem : rem;
        case (op)
            MD_MUL:                       res_fix = prod_s[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res_fix = prod_s[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:              res_fix = quo_s;
            default:                      res_fix = rem_s;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    // Next state and handshake outputs; flush overrides everything
    always_comb begin
        nxt  = state;
        busy = (state == ST_CALC) || (state == ST_FIX);
        done = (state == ST_DONE);
        if (flush) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) nxt = fast ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt == '0) nxt = ST_FIX;
                ST_FIX:  nxt = ST_DONE;
                ST_DONE: nxt = accept ? (fast ? ST_DONE : ST_CALC) : ST_IDLE;
                default: nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath: capture on accept, iterate in CALC, write result in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op       <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            mcand    <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            mdresult <= '0;
        end else if (accept) begin
            cnt   <= CW'(WIDTH - 1);
            op    <= mdcontrol;
            sa    <= in_sa;
            sb    <= in_sb;
            mcand <= bmag;
            prod  <= {{WIDTH{1'b0}}, amag};
            rem   <= '0;
            quo   <= amag;
            if (fast)
                mdresult <= fast_res;
        end else if (!flush && state == ST_CALC) begin
            cnt <= cnt - 1'b1;
            if (op[2]) begin
                rem <= rdiff[WIDTH] ? rtrial[WIDTH-1:0] : rdiff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], ~rdiff[WIDTH]};
            end else begin
                prod <= {msum, prod[WIDTH-1:1]};
            end
        end else if (!flush && state == ST_FIX) begin
            mdresult <= res_fix;
        end
    end

endmodule
